// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: ALU control codes, FSM states,
// datapath width and the request payload bundle.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [CTRL_W-1:0] ctrl;
  } req_t;

  // Only MUL needs extra settle time; every other code, known or not, is single-cycle.
  function automatic logic is_mul(input logic [CTRL_W-1:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// port that was not granted last.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant0_o,
  output logic grant1_o
);

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (valid0_i && valid1_i) begin
      grant0_o = last_grant_i;
      grant1_o = ~last_grant_i;
    end else begin
      grant0_o = valid0_i;
      grant1_o = valid1_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two request ports onto the shared ALU, holds operands for the
// required settle time and returns the captured result on a tagged response port.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic [3:0]        req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  input  logic [3:0]        req1_ctrl_i,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_zero_o,
  output logic              busy_o
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0] alu_data2_q, alu_data2_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic grant0, grant1;
  logic accept;
  req_t req0_pl, req1_pl, sel_pl;

  rr_arb2 u_rr_arb2 (
    .valid0_i     (req0_valid_i),
    .valid1_i     (req1_valid_i),
    .last_grant_i (last_grant_q),
    .grant0_o     (grant0),
    .grant1_o     (grant1)
  );

  // Ready is gated by rst_i so nothing looks accepted while reset is held.
  assign req0_ready_o = rst_i && (state_q == IDLE) && grant0;
  assign req1_ready_o = rst_i && (state_q == IDLE) && grant1;
  assign accept       = req0_ready_o || req1_ready_o;

  assign req0_pl = '{op1: req0_op1_i, op2: req0_op2_i, ctrl: req0_ctrl_i};
  assign req1_pl = '{op1: req1_op1_i, op2: req1_op2_i, ctrl: req1_ctrl_i};
  assign sel_pl  = req1_ready_o ? req1_pl : req0_pl;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d        = req1_ready_o;
          alu_data1_d = sel_pl.op1;
          alu_data2_d = sel_pl.op2;
          alu_ctrl_d  = sel_pl.ctrl;
          cnt_d       = is_mul(sel_pl.ctrl) ? MUL_LOAD : '0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d = alu_data_i;
          rsp_zero_d = (alu_data_i == '0);
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_ctrl_q   <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_data1_o = alu_data1_q;
  assign alu_data2_o = alu_data2_q;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign rsp_id_o    = id_q;
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a bench-side ALU, a transaction-level model
// compared every cycle, and hand-computed expectations for each scenario.
module tb_alu_arbiter;

  localparam int unsigned MCY = 3;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        zero;
    int          lat;
    int          execn;
    logic [31:0] alu_cap;
    int          acc;
  } done_t;

  logic        clk;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
  logic [3:0]  req0_ctrl_i, req1_ctrl_i;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i, rsp_data_o;
  logic [3:0]  alu_ctrl_o;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  op_t   q0[$];
  op_t   q1[$];
  done_t done[$];
  int    grants[$];
  int    accs[$];

  alu_arbiter #(.MUL_CYCLES(MCY)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_op1_i   (req0_op1_i),
    .req0_op2_i   (req0_op2_i),
    .req0_ctrl_i  (req0_ctrl_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_op1_i   (req1_op1_i),
    .req1_op2_i   (req1_op2_i),
    .req1_ctrl_i  (req1_ctrl_i),
    .alu_data1_o  (alu_data1_o),
    .alu_data2_o  (alu_data2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_data_i   (alu_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_zero_o   (rsp_zero_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1000: return a * b;
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_data_i = alu_f(alu_data1_o, alu_data2_o, alu_ctrl_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one operation in flight, result due after its latency.
  logic        m_have, m_last, m_id, m_zero;
  int          m_wait;
  logic [31:0] m_d1, m_d2, m_res;
  logic [3:0]  m_ctrl;
  logic        exp_r0, exp_r1;

  assign exp_r0 = rst_i && !m_have && req0_valid_i && (!req1_valid_i || m_last);
  assign exp_r1 = rst_i && !m_have && req1_valid_i && (!req0_valid_i || !m_last);

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_have <= 1'b0; m_last <= 1'b1; m_id <= 1'b0; m_wait <= 0;
      m_d1 <= '0; m_d2 <= '0; m_ctrl <= '0; m_res <= '0; m_zero <= 1'b0;
    end else if (!m_have) begin
      if (exp_r0 || exp_r1) begin
        m_have <= 1'b1;
        m_id   <= exp_r1;
        m_d1   <= exp_r1 ? req1_op1_i  : req0_op1_i;
        m_d2   <= exp_r1 ? req1_op2_i  : req0_op2_i;
        m_ctrl <= exp_r1 ? req1_ctrl_i : req0_ctrl_i;
        m_wait <= ((exp_r1 ? req1_ctrl_i : req0_ctrl_i) == 4'b1000) ? int'(MCY) : 1;
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_res  <= alu_f(m_d1, m_d2, m_ctrl);
        m_zero <= (alu_f(m_d1, m_d2, m_ctrl) == 32'd0);
      end
    end else if (rsp_ready_i) begin
      m_have <= 1'b0;
      m_last <= m_id;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("req0_ready", req0_ready_o, exp_r0);
      chk("req1_ready", req1_ready_o, exp_r1);
      chk("alu_data1", alu_data1_o, m_d1);
      chk("alu_data2", alu_data2_o, m_d2);
      chk("alu_ctrl", alu_ctrl_o, m_ctrl);
      chk("rsp_valid", rsp_valid_o, m_have && (m_wait == 0));
      chk("rsp_id", rsp_id_o, m_id);
      chk("rsp_data", rsp_data_o, m_res);
      chk("rsp_zero", rsp_zero_o, m_zero);
      chk("busy", busy_o, m_have);
    end
  end

  // Requester drivers: present queue head, hold it until accepted.
  initial begin
    logic hs;
    forever begin
      @(negedge clk);
      hs = req0_valid_i && req0_ready_o;
      @(posedge clk);
      #1;
      if (hs && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0_valid_i = 1'b1; req0_op1_i = q0[0].op1; req0_op2_i = q0[0].op2; req0_ctrl_i = q0[0].ctrl;
      end else begin
        req0_valid_i = 1'b0;
      end
    end
  end

  initial begin
    logic hs;
    forever begin
      @(negedge clk);
      hs = req1_valid_i && req1_ready_o;
      @(posedge clk);
      #1;
      if (hs && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid_i = 1'b1; req1_op1_i = q1[0].op1; req1_op2_i = q1[0].op2; req1_ctrl_i = q1[0].ctrl;
      end else begin
        req1_valid_i = 1'b0;
      end
    end
  end

  // Transaction monitor: accept cycles, grant order, latency, completed responses.
  initial begin
    logic        prev_v;
    int          acc_c, lat, execn;
    logic [31:0] cap;
    prev_v = 1'b0; acc_c = 0; lat = 0; execn = 0; cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        prev_v = 1'b0;
        continue;
      end
      if (req0_valid_i && req0_ready_o) begin
        acc_c = cyc; execn = 0; grants.push_back(0); accs.push_back(cyc);
      end
      if (req1_valid_i && req1_ready_o) begin
        acc_c = cyc; execn = 0; grants.push_back(1); accs.push_back(cyc);
      end
      if (busy_o && !rsp_valid_o) begin
        execn++;
        cap = alu_data_i;
      end
      if (rsp_valid_o && !prev_v) lat = cyc - acc_c;
      if (rsp_valid_o && rsp_ready_i)
        done.push_back('{id: int'(rsp_id_o), data: rsp_data_o, zero: rsp_zero_o,
                         lat: lat, execn: execn, alu_cap: cap, acc: acc_c});
      prev_v = rsp_valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    q0.push_back('{op1: a, op2: b, ctrl: c});
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    q1.push_back('{op1: a, op2: b, ctrl: c});
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("done_count", done.size(), n);
  endtask

  initial begin
    int base, rel, k;
    int exp_g[6];
    exp_g = '{0, 1, 0, 1, 0, 1};
    rst_i = 1'b0; rsp_ready_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_op1_i = '0; req0_op2_i = '0; req0_ctrl_i = '0;
    req1_op1_i = '0; req1_op2_i = '0; req1_ctrl_i = '0;
    repeat (3) tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", rsp_valid_o, 1'b0);
    chk("rst_data", rsp_data_o, 32'd0);
    rst_i = 1'b1;
    tick();

    // Reset in the middle of a MUL aborts it.
    push0(32'd3, 32'd4, 4'b1000);
    k = 0;
    while (!busy_o && k < 50) begin tick(); k++; end
    chk("mul_busy_seen", busy_o, 1'b1);
    tick();
    rst_i = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_valid", rsp_valid_o, 1'b0);
    chk("midrst_d1", alu_data1_o, 32'd0);
    chk("midrst_d2", alu_data2_o, 32'd0);
    chk("midrst_ctrl", alu_ctrl_o, 4'd0);
    chk("midrst_data", rsp_data_o, 32'd0);
    chk("midrst_zero", rsp_zero_o, 1'b0);
    chk("midrst_id", rsp_id_o, 1'b0);
    chk("midrst_rdy0", req0_ready_o, 1'b0);
    tick(); tick();
    rst_i = 1'b1;
    repeat (8) tick();
    chk("no_rsp_after_rst", done.size(), 0);

    // ADD 5+7 after reset.
    base = done.size();
    push0(32'd5, 32'd7, 4'b0010);
    wait_done(base + 1);
    chk("add_data", done[base].data, 32'd12);
    chk("add_id", done[base].id, 0);
    chk("add_lat", done[base].lat, 2);

    // MUL 6*7 on port 1.
    base = done.size();
    push1(32'd6, 32'd7, 4'b1000);
    wait_done(base + 1);
    chk("mul_data", done[base].data, 32'd42);
    chk("mul_id", done[base].id, 1);
    chk("mul_lat", done[base].lat, 4);
    chk("mul_exec_cycles", done[base].execn, 3);

    // Tie: port 0 wins since port 1 was granted last.
    base = done.size();
    push0(32'd9, 32'd9, 4'b0110);
    push1(32'hF0, 32'h0F, 4'b0001);
    wait_done(base + 2);
    chk("tie_first_id", done[base].id, 0);
    chk("tie_first_zero", done[base].zero, 1'b1);
    chk("tie_first_data", done[base].data, 32'd0);
    chk("tie_second_id", done[base+1].id, 1);
    chk("tie_second_data", done[base+1].data, 32'hFF);
    chk("tie_second_zero", done[base+1].zero, 1'b0);

    // Fairness: both ports continuously valid.
    base = done.size();
    grants.delete();
    accs.delete();
    for (int i = 0; i < 3; i++) begin
      push0(32'd10 + i, 32'd1, 4'b0010);
      push1(32'd20 + i, 32'd3, 4'b0110);
    end
    wait_done(base + 6);
    chk("fair_grant_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk("fair_grant", grants[i], exp_g[i]);
    for (int i = 1; i < 6 && i < accs.size(); i++)
      chk("fair_spacing", accs[i] - accs[i-1], 3);
    chk("fair_last_data", done[base+5].data, 32'd19);

    // Backpressure: response held while port 0 waits.
    base = done.size();
    rsp_ready_i = 1'b0;
    push1(32'd100, 32'd23, 4'b0010);
    k = 0;
    while (!rsp_valid_o && k < 50) begin tick(); k++; end
    chk("bp_valid_seen", rsp_valid_o, 1'b1);
    push0(32'd50, 32'd8, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", rsp_valid_o, 1'b1);
      chk("bp_data_held", rsp_data_o, 32'd123);
      chk("bp_rdy0_low", req0_ready_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    rel = cyc;
    wait_done(base + 2);
    chk("bp_first_data", done[base].data, 32'd123);
    chk("bp_first_id", done[base].id, 1);
    chk("bp_accept_cycle", done[base+1].acc, rel + 1);
    chk("bp_second_data", done[base+1].data, 32'd42);

    // Unknown ctrl: forwarded, single-cycle path.
    base = done.size();
    push0(32'h1234_0000, 32'h0000_5678, 4'b1111);
    wait_done(base + 1);
    chk("unk_lat", done[base].lat, 2);
    chk("unk_cap", done[base].data, done[base].alu_cap);
    chk("unk_data", done[base].data, 32'hCC99_E897);
    chk("unk_ctrl_fwd", alu_ctrl_o, 4'b1111);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operations from two independent valid/ready request ports, grants one at a time by round-robin, and drives the ALU operand and control inputs from registers. It holds MUL operations for a configurable number of settle cycles, then returns the registered result on a single tagged valid/ready response port. It sits between the issue logic and the ALU.

## Interface
- MUL_CYCLES, 3, cycles the ALU inputs are held for ctrl 4'b1000 (MUL) before capture; legal range 1..15
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- req0_valid_i / req1_valid_i  in  1  request pending on port 0 / 1
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- req0_op1_i, req0_op2_i / req1_op1_i, req1_op2_i  in  32  operands
- req0_ctrl_i / req1_ctrl_i  in  4  ALU control: ADD 0010, SUB 0110, AND 0000, OR 0001, MUL 1000
- alu_data1_o, alu_data2_o  out  32  registered operands to the ALU
- alu_ctrl_o  out  4  registered control to the ALU
- alu_data_i  in  32  ALU combinational result
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer takes the result
- rsp_id_o  out  1  requester that owns the result
- rsp_data_o  out  32  captured result
- rsp_zero_o  out  1  high when rsp_data_o == 0
- busy_o  out  1  high when state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE: the arbiter computes a grant from the valid inputs.
  - If only one valid is high, that port is granted.
  - If both are high, the port not equal to last_grant is granted.
  - ready_o is high only for the granted port, combinationally, and only in IDLE.
- Handshake (valid & ready):
  - Latch op1, op2 and ctrl into alu_data1_o, alu_data2_o and alu_ctrl_o, and the port number into id.
  - Load cnt = (ctrl == MUL) ? MUL_CYCLES-1 : 0, then go to EXEC.
- EXEC:
  - If cnt == 0: capture alu_data_i into rsp_data_o, set rsp_zero_o = (alu_data_i == 0), go to RESP.
  - Otherwise cnt decrements.
- RESP:
  - rsp_valid_o is high, and rsp_id_o = id.
  - On rsp_ready_i: last_grant <= id, then go to IDLE.
  - With rsp_ready_i low, the response holds indefinitely and all outputs stay stable.
- Unknown ctrl codes are forwarded unchanged and use the 1-cycle path.
- ALU outputs keep the last operation's values outside EXEC. No request is accepted in EXEC or RESP.
- cnt is 4 bits wide. Results are the ALU's 32 bits with no widening.

## Timing
- Reset (rst_i low, asynchronous):
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - cnt = 0, id = 0.
  - All outputs are 0, except that the ready outputs follow the grant logic as soon as reset releases.
- Latency from the handshake edge to rsp_valid_o high:
  - Non-MUL: 2 cycles (1 EXEC cycle).
  - MUL: MUL_CYCLES+1 cycles.
- Minimum spacing between accepts is 3 cycles for non-MUL operations: accept, EXEC, RESP with immediate ready, then IDLE.
- A request that arrives while busy waits with valid held. The requester must hold valid and its payload stable until ready.
- Simultaneous response and new request: the new request is not accepted in the RESP cycle. It is accepted in the following IDLE cycle, with last_grant already updated.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. No response is emitted after reset.

## Structure
- Shared package alu_pkg:
  - ALU control constants (ADD, SUB, AND, OR, MUL).
  - State enum {IDLE, EXEC, RESP}.
  - The 32-bit data width constant.
- Sub-module rr_arb2: a 2-way round-robin grant from (valid0, valid1, last_grant), purely combinational. The FSM, counter and registers stay in alu_arbiter.

## Test plan
- Reset: hold rst_i low mid-MUL → all outputs 0, busy_o 0. After release, req0 ADD 5+7 with rsp_ready_i=1 → rsp_data_o=12, rsp_id_o=0, 2 cycles after the accept.
- Tie: both valid in the same cycle, req0 SUB 9-9, req1 OR 0xF0|0x0F → req0 is served first with rsp_zero_o=1. req1 is served next with rsp_data_o=0xFF, rsp_id_o=1.
- Fairness: both valid continuously for 6 operations → grants alternate 0,1,0,1,0,1.
- MUL latency: MUL_CYCLES=3, req1 MUL 6*7 → ALU inputs stable for 3 cycles, rsp_valid_o rises 4 cycles after the accept, rsp_data_o=42.
- Backpressure: rsp_ready_i low for 5 cycles while req0 is waiting → rsp_valid_o stays high with data stable, req0_ready_o stays low, and req0 is accepted one cycle after rsp_ready_i rises.
- Unknown ctrl 4'b1111 → the operation completes with 1-cycle latency, and rsp_data_o equals alu_data_i sampled at capture.
